calc_sequencer: RTL and testbench

Keypad-driven controller that sequences the signed calculator core. It takes decoded key strobes, builds two signed decimal operands and an operator, and issues exactly one operation to the core per equals press. It captures the core's magnitude/sign result and drives the display value. It sits between the keypad encoder and the calculator core, and is the only block that writes the core's operand and operator inputs.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_operand_entry.sv | 66 ++++++
 rtl/calc_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, widths and sequencer state encoding for the calculator controller.
package calc_pkg;

  localparam int OPND_W = 10;
  localparam int CORE_W = 11;
  localparam int RES_W  = 21;

  localparam logic [3:0] KEY_NEG = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_SUB  = 4'hE;
  localparam logic [3:0] OP_ADD  = 4'hF;
  localparam logic [3:0] OP_NONE = 4'h0;

  typedef enum logic [2:0] {
    S_OP1,
    S_OP2,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic logic is_op_key(input logic [3:0] k);
    return (k == OP_MUL) || (k == OP_SUB) || (k == OP_ADD);
  endfunction

endpackage

// File: rtl/calc_operand_entry.sv
// One signed decimal operand: magnitude/neg registers with saturating x10 digit entry.
// Control inputs act at the next edge; the registered two's-complement view follows the same edge.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int MAX_MAG = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              digit_vld,
  input  logic [3:0]        digit,
  input  logic              neg_tgl,
  input  logic              load_vld,
  input  logic [OPND_W-1:0] load_mag,
  input  logic              load_neg,
  output logic [OPND_W-1:0] mag_nxt,
  output logic              neg_nxt,
  output logic [CORE_W-1:0] twos
);

  localparam logic [13:0] MAX_MAG_W = 14'(MAX_MAG);

  logic [OPND_W-1:0] mag_q, mag_d;
  logic              neg_q, neg_d;
  logic [CORE_W-1:0] twos_q, twos_d;
  logic [13:0]       acc;

  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    acc   = '0;
    if (clr) begin
      mag_d = '0;
      neg_d = 1'b0;
    end
    if (load_vld) begin
      mag_d = load_mag;
      neg_d = load_neg;
    end
    // Builds on mag_d so a clear-plus-digit in one cycle starts a fresh operand.
    if (digit_vld) begin
      acc = {4'b0, mag_d} * 14'd10 + {10'b0, digit};
      if (acc <= MAX_MAG_W) mag_d = acc[OPND_W-1:0];
    end
    if (neg_tgl) neg_d = ~neg_q;
    twos_d = neg_d ? (~{1'b0, mag_d} + 11'd1) : {1'b0, mag_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      twos_q <= '0;
    end else begin
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      twos_q <= twos_d;
    end
  end

  assign mag_nxt = mag_d;
  assign neg_nxt = neg_d;
  assign twos    = twos_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad sequencer for the signed calculator core; one core op per equals, result after 3 edges.
// No backpressure: keys are ignored in EXEC/WAIT. Operator chaining from DONE needs CALC_CHAIN_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_MAG = 1023
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [3:0]        keyCode,
  input  logic              keyValid,
  output logic [CORE_W-1:0] coreOperand1,
  output logic [CORE_W-1:0] coreOperand2,
  output logic [3:0]        coreOperator,
  input  logic [RES_W-1:0]  coreAnswer,
  input  logic              coreSign,
  output logic [RES_W-1:0]  displayValue,
  output logic              displaySign,
  output logic              busy,
  output logic              resultValid
);

  state_t            state_q, state_d;
  logic [3:0]        oper_q, oper_d;
  logic              op2_dig_q, op2_dig_d;
  logic [RES_W-1:0]  res_mag_q, res_mag_d;
  logic              res_sign_q, res_sign_d;
  logic [3:0]        core_op_q, core_op_d;
  logic [RES_W-1:0]  disp_val_q, disp_val_d;
  logic              disp_sign_q, disp_sign_d;
  logic              busy_q, busy_d;
  logic              res_vld_q, res_vld_d;

  logic              is_digit, is_neg, is_clr, is_eq, is_op;
  logic              e1_clr, e1_dig, e1_neg, e1_load, e1_load_neg;
  logic [OPND_W-1:0] e1_load_mag;
  logic              e2_clr, e2_dig, e2_neg;
  logic [OPND_W-1:0] e1_mag_nxt, e2_mag_nxt;
  logic              e1_neg_nxt, e2_neg_nxt;

  assign is_digit = keyValid && (keyCode <= 4'd9);
  assign is_neg   = keyValid && (keyCode == KEY_NEG);
  assign is_clr   = keyValid && (keyCode == KEY_CLR);
  assign is_eq    = keyValid && (keyCode == KEY_EQ);
  assign is_op    = keyValid && is_op_key(keyCode);

`ifdef CALC_CHAIN_EN
  localparam logic [RES_W-1:0] MAX_RES = RES_W'(MAX_MAG);
  logic chain_ok;
  assign chain_ok = (res_mag_q <= MAX_RES);
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_OP1;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP1:  if (is_op) state_d = S_OP2;
      S_OP2:  if (is_clr) state_d = S_OP1;
              else if (is_eq) state_d = S_EXEC;
      S_EXEC: state_d = S_WAIT;
      S_WAIT: state_d = S_DONE;
      S_DONE: begin
        if (is_digit || is_clr) state_d = S_OP1;
`ifdef CALC_CHAIN_EN
        else if (is_op && chain_ok) state_d = S_OP2;
`endif
      end
      default: state_d = S_OP1;
    endcase
  end

  always_comb begin
    e1_clr      = 1'b0;
    e1_dig      = 1'b0;
    e1_neg      = 1'b0;
    e1_load     = 1'b0;
    e1_load_mag = '0;
    e1_load_neg = 1'b0;
    e2_clr      = 1'b0;
    e2_dig      = 1'b0;
    e2_neg      = 1'b0;
    oper_d      = oper_q;
    op2_dig_d   = op2_dig_q;
    res_mag_d   = res_mag_q;
    res_sign_d  = res_sign_q;
    case (state_q)
      S_OP1: begin
        e1_dig = is_digit;
        e1_neg = is_neg;
        if (is_op) begin
          oper_d    = keyCode;
          e2_clr    = 1'b1;
          op2_dig_d = 1'b0;
        end
      end
      S_OP2: begin
        e2_dig = is_digit;
        e2_neg = is_neg;
        if (is_digit) op2_dig_d = 1'b1;
        if (is_op && !op2_dig_q) oper_d = keyCode;
      end
      S_WAIT: begin
        res_mag_d  = coreAnswer;
        res_sign_d = coreSign;
      end
      S_DONE: begin
        if (is_digit) begin
          e1_clr     = 1'b1;
          e1_dig     = 1'b1;
          e2_clr     = 1'b1;
          oper_d     = OP_NONE;
          op2_dig_d  = 1'b0;
          res_mag_d  = '0;
          res_sign_d = 1'b0;
        end
`ifdef CALC_CHAIN_EN
        if (is_op && chain_ok) begin
          e1_load     = 1'b1;
          e1_load_mag = res_mag_q[OPND_W-1:0];
          e1_load_neg = res_sign_q;
          oper_d      = keyCode;
          e2_clr      = 1'b1;
          op2_dig_d   = 1'b0;
        end
`endif
      end
      default: ;
    endcase
    if (is_clr && (state_q == S_OP1 || state_q == S_OP2 || state_q == S_DONE)) begin
      e1_clr     = 1'b1;
      e2_clr     = 1'b1;
      oper_d     = OP_NONE;
      op2_dig_d  = 1'b0;
      res_mag_d  = '0;
      res_sign_d = 1'b0;
    end
  end

  calc_operand_entry #(.MAX_MAG(MAX_MAG)) u_opnd1 (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .clr       (e1_clr),
    .digit_vld (e1_dig),
    .digit     (keyCode),
    .neg_tgl   (e1_neg),
    .load_vld  (e1_load),
    .load_mag  (e1_load_mag),
    .load_neg  (e1_load_neg),
    .mag_nxt   (e1_mag_nxt),
    .neg_nxt   (e1_neg_nxt),
    .twos      (coreOperand1)
  );

  calc_operand_entry #(.MAX_MAG(MAX_MAG)) u_opnd2 (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .clr       (e2_clr),
    .digit_vld (e2_dig),
    .digit     (keyCode),
    .neg_tgl   (e2_neg),
    .load_vld  (1'b0),
    .load_mag  ('0),
    .load_neg  (1'b0),
    .mag_nxt   (e2_mag_nxt),
    .neg_nxt   (e2_neg_nxt),
    .twos      (coreOperand2)
  );

  // Outputs are computed from next-state values so every change lands on the accepting edge.
  always_comb begin
    disp_val_d  = disp_val_q;
    disp_sign_d = disp_sign_q;
    case (state_d)
      S_OP1: begin
        disp_val_d  = {{(RES_W-OPND_W){1'b0}}, e1_mag_nxt};
        disp_sign_d = e1_neg_nxt;
      end
      S_OP2: begin
        disp_val_d  = {{(RES_W-OPND_W){1'b0}}, e2_mag_nxt};
        disp_sign_d = e2_neg_nxt;
      end
      S_DONE: begin
        disp_val_d  = res_mag_d;
        disp_sign_d = res_sign_d;
      end
      default: ;
    endcase
    busy_d    = (state_d == S_EXEC) || (state_d == S_WAIT);
    res_vld_d = (state_d == S_DONE);
    core_op_d = (state_d == S_EXEC) ? oper_q : OP_NONE;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      oper_q      <= OP_NONE;
      op2_dig_q   <= 1'b0;
      res_mag_q   <= '0;
      res_sign_q  <= 1'b0;
      core_op_q   <= OP_NONE;
      disp_val_q  <= '0;
      disp_sign_q <= 1'b0;
      busy_q      <= 1'b0;
      res_vld_q   <= 1'b0;
    end else begin
      oper_q      <= oper_d;
      op2_dig_q   <= op2_dig_d;
      res_mag_q   <= res_mag_d;
      res_sign_q  <= res_sign_d;
      core_op_q   <= core_op_d;
      disp_val_q  <= disp_val_d;
      disp_sign_q <= disp_sign_d;
      busy_q      <= busy_d;
      res_vld_q   <= res_vld_d;
    end
  end

  assign coreOperator = core_op_q;
  assign displayValue = disp_val_q;
  assign displaySign  = disp_sign_q;
  assign busy         = busy_q;
  assign resultValid  = res_vld_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: issued equals push expected core ops and results,
// a negedge monitor pops and compares when the DUT presents them; includes a core model.
module tb_calc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  keyCode = 4'h0;
  logic        keyValid = 1'b0;
  logic [10:0] coreOperand1, coreOperand2;
  logic [3:0]  coreOperator;
  logic [20:0] coreAnswer = '0;
  logic        coreSign = 1'b0;
  logic [20:0] displayValue;
  logic        displaySign;
  logic        busy, resultValid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [3:0] op; logic [10:0] a; logic [10:0] b; } op_exp_t;
  typedef struct { logic [20:0] mag; logic sign; } res_exp_t;
  op_exp_t  op_q[$];
  res_exp_t res_q[$];

  calc_sequencer #(.MAX_MAG(1023)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .keyCode      (keyCode),
    .keyValid     (keyValid),
    .coreOperand1 (coreOperand1),
    .coreOperand2 (coreOperand2),
    .coreOperator (coreOperator),
    .coreAnswer   (coreAnswer),
    .coreSign     (coreSign),
    .displayValue (displayValue),
    .displaySign  (displaySign),
    .busy         (busy),
    .resultValid  (resultValid)
  );

  always #5 Clock = ~Clock;

  // Signed core: registers its answer one edge after the operator is presented.
  always @(posedge Clock) begin
    int a, b, r;
    if (coreOperator != 4'h0) begin
      a = int'($signed(coreOperand1));
      b = int'($signed(coreOperand2));
      case (coreOperator)
        4'hD:    r = a * b;
        4'hE:    r = a - b;
        default: r = a + b;
      endcase
      coreAnswer <= (r < 0) ? 21'(-r) : 21'(r);
      coreSign   <= (r < 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  logic prev_op = 1'b0;
  logic prev_rv = 1'b0;
  always @(negedge Clock) begin
    op_exp_t  eo;
    res_exp_t er;
    if (!Reset_n) begin
      prev_op = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (coreOperator != 4'h0) begin
        if (prev_op) begin
          n_checks++; n_errors++;
          $display("FAIL op_pulse: operator %0h held for more than one cycle", coreOperator);
        end else if (op_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL op_unexpected: got operator %0h expected none", coreOperator);
        end else begin
          eo = op_q.pop_front();
          check("core_operator", 32'(coreOperator), 32'(eo.op));
          check("core_operand1", 32'(coreOperand1), 32'(eo.a));
          check("core_operand2", 32'(coreOperand2), 32'(eo.b));
          check("busy_in_exec", 32'(busy), 32'd1);
        end
      end
      if (resultValid && !prev_rv) begin
        if (res_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL res_unexpected: got result %0d expected none", displayValue);
        end else begin
          er = res_q.pop_front();
          check("result_value", 32'(displayValue), 32'(er.mag));
          check("result_sign", 32'(displaySign), 32'(er.sign));
        end
      end
      prev_op = (coreOperator != 4'h0);
      prev_rv = resultValid;
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge Clock);
    keyCode  = k;
    keyValid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      keyValid = 1'b0;
    end
  endtask

  task automatic expect_op(input logic [3:0] op, input logic [10:0] a, input logic [10:0] b);
    op_q.push_back('{op: op, a: a, b: b});
  endtask

  task automatic expect_res(input logic [20:0] mag, input logic sign);
    res_q.push_back('{mag: mag, sign: sign});
  endtask

  task automatic wait_result();
    int n = 0;
    while (!resultValid && n < 10) begin
      @(negedge Clock);
      keyValid = 1'b0;
      n++;
    end
    check("result_wait", 32'(resultValid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_operand1", 32'(coreOperand1), 32'd0);
    check("rst_operand2", 32'(coreOperand2), 32'd0);
    check("rst_operator", 32'(coreOperator), 32'd0);
    check("rst_display", 32'(displayValue), 32'd0);
    check("rst_sign", 32'(displaySign), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resultValid), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // 12 * -3
    expect_op(4'hD, 11'd12, 11'h7FD);
    expect_res(21'd36, 1'b1);
    press(4'd1); press(4'd2); press(4'hD); press(4'd3); press(4'hA); press(4'hC);
    idle(1);
    wait_result();
    check("t1_display", 32'(displayValue), 32'd36);

    // Operator from DONE
`ifdef CALC_CHAIN_EN
    expect_op(4'hF, 11'h7DC, 11'd40);
    expect_res(21'd4, 1'b0);
    press(4'hF); press(4'd4); press(4'd0); press(4'hC);
    idle(1);
    wait_result();
    check("chain_sign", 32'(displaySign), 32'd0);
`else
    press(4'hF); press(4'd4); press(4'd0); press(4'hC);
    idle(4);
    check("nochain_valid", 32'(resultValid), 32'd0);
    check("nochain_busy", 32'(busy), 32'd0);
    check("nochain_display", 32'(displayValue), 32'd40);
    check("nochain_operand1", 32'(coreOperand1), 32'd40);
`endif
    press(4'hB); idle(1);

    // 5 - 9, then clear
    expect_op(4'hE, 11'd5, 11'd9);
    expect_res(21'd4, 1'b1);
    press(4'd5); press(4'hE); press(4'd9); press(4'hC);
    idle(1);
    wait_result();
    press(4'hB); idle(1);
    check("clr_display", 32'(displayValue), 32'd0);
    check("clr_sign", 32'(displaySign), 32'd0);
    check("clr_valid", 32'(resultValid), 32'd0);
    check("clr_operand1", 32'(coreOperand1), 32'd0);

    // Saturation at MAX_MAG, then keys during EXEC/WAIT ignored
    press(4'd1); press(4'd0); press(4'd2); press(4'd4);
    idle(1);
    check("sat_display", 32'(displayValue), 32'd102);
    check("sat_operand1", 32'(coreOperand1), 32'd102);
    expect_op(4'hD, 11'd102, 11'd5);
    expect_res(21'd510, 1'b0);
    press(4'hD); press(4'd5); press(4'hC);
    press(4'd7); press(4'd7);
    idle(1);
    wait_result();
    check("busy_display", 32'(displayValue), 32'd510);
    idle(2);
    check("busy_still_done", 32'(resultValid), 32'd1);
    press(4'hB); idle(1);

    // Reset during EXEC
    expect_op(4'hD, 11'd3, 11'd2);
    press(4'd3); press(4'hD); press(4'd2); press(4'hC);
    @(negedge Clock);
    keyValid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    check("arst_operator", 32'(coreOperator), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_operand1", 32'(coreOperand1), 32'd0);
    check("arst_operand2", 32'(coreOperand2), 32'd0);
    check("arst_display", 32'(displayValue), 32'd0);
    check("arst_valid", 32'(resultValid), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    press(4'd6); idle(1);
    check("post_rst_display", 32'(displayValue), 32'd6);
    check("post_rst_operand1", 32'(coreOperand1), 32'd6);
    check("post_rst_busy", 32'(busy), 32'd0);

    idle(5);
    check("op_queue_empty", 32'(op_q.size()), 32'd0);
    check("res_queue_empty", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
